// File: rtl/demux_seq_pkg.sv
// Shared constants and state encoding for the demux frame sequencer.
package demux_seq_pkg;
    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;
endpackage

// File: rtl/demux_frame_sequencer_hold_timer.sv
// Per-channel dwell counter: counts 0..HOLD_CYCLES-1 and flags the final cycle.
module hold_timer #(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic last
);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // load restarts the dwell; the owner reloads on the last cycle so the count never wraps
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == CNT_LAST);
endmodule

// File: rtl/demux_frame_sequencer.sv
// Serialises an 8-bit frame onto the demux data/sel pair, one channel per HOLD_CYCLES cycles.
module demux_frame_sequencer
    import demux_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter bit          MSB_FIRST   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] frame_in,
    input  logic              frame_valid,
    output logic              frame_ready,
    input  logic              abort,
    output logic              data,
    output logic [SEL_W-1:0]  sel,
    output logic              bit_valid,
    output logic              frame_done
);
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("HOLD_CYCLES must be in 1..255");
    end

    localparam logic [SEL_W-1:0] FIRST_CH = MSB_FIRST ? SEL_W'(NUM_CH - 1) : '0;
    localparam logic [SEL_W-1:0] FINAL_CH = MSB_FIRST ? '0 : SEL_W'(NUM_CH - 1);

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] frame_q, frame_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              data_q, data_d;
    logic              bit_valid_q, bit_valid_d;
    logic              tmr_load, tmr_en, tmr_last;
    logic              accept;

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk (clk),
        .rst (rst),
        .load(tmr_load),
        .en  (tmr_en),
        .last(tmr_last)
    );

    // Ready on the final hold cycle as well as in IDLE, giving back-to-back frames.
    assign frame_done  = (state_q == SHIFT) && tmr_last && (sel_q == FINAL_CH);
    assign frame_ready = !rst && ((state_q == IDLE) || frame_done);
    assign accept      = frame_valid && frame_ready;

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        sel_d       = sel_q;
        data_d      = data_q;
        bit_valid_d = bit_valid_q;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = SHIFT;
                    frame_d     = frame_in;
                    sel_d       = FIRST_CH;
                    data_d      = frame_in[FIRST_CH];
                    bit_valid_d = 1'b1;
                    tmr_load    = 1'b1;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d     = IDLE;
                    sel_d       = '0;
                    data_d      = 1'b0;
                    bit_valid_d = 1'b0;
                    tmr_load    = 1'b1;
                end else if (!tmr_last) begin
                    tmr_en = 1'b1;
                end else if (sel_q != FINAL_CH) begin
                    sel_d    = MSB_FIRST ? sel_q - SEL_W'(1) : sel_q + SEL_W'(1);
                    data_d   = frame_q[sel_d];
                    tmr_load = 1'b1;
                end else if (frame_valid) begin
                    frame_d  = frame_in;
                    sel_d    = FIRST_CH;
                    data_d   = frame_in[FIRST_CH];
                    tmr_load = 1'b1;
                end else begin
                    state_d     = IDLE;
                    sel_d       = '0;
                    data_d      = 1'b0;
                    bit_valid_d = 1'b0;
                    tmr_load    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            sel_q       <= '0;
            data_q      <= 1'b0;
            bit_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
            bit_valid_q <= bit_valid_d;
        end
    end

    assign data      = data_q;
    assign sel       = sel_q;
    assign bit_valid = bit_valid_q;
endmodule

// File: tb/tb_demux_frame_sequencer.sv
// Directed bench: table of per-cycle vectors for a HOLD=1/LSB-first instance, plus a HOLD=3/MSB-first sequence.
module tb_demux_frame_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] frame_in;
    logic       frame_valid;
    logic       abort;

    logic       rdy_a, data_a, bv_a, done_a;
    logic [2:0] sel_a;
    logic       rdy_b, data_b, bv_b, done_b;
    logic [2:0] sel_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    demux_frame_sequencer #(.HOLD_CYCLES(1), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(frame_valid),
        .frame_ready(rdy_a), .abort(abort), .data(data_a), .sel(sel_a),
        .bit_valid(bv_a), .frame_done(done_a)
    );

    demux_frame_sequencer #(.HOLD_CYCLES(3), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(frame_valid),
        .frame_ready(rdy_b), .abort(abort), .data(data_b), .sel(sel_b),
        .bit_valid(bv_b), .frame_done(done_b)
    );

    // exp packs {frame_ready, bit_valid, sel[2:0], data, frame_done} for the current cycle
    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] fr;
        logic       abrt;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic [7:0] f, input logic a,
                       input logic er, input logic ebv, input logic [2:0] es,
                       input logic ed, input logic edn);
        vec_t t;
        t.rst  = r;
        t.vld  = v;
        t.fr   = f;
        t.abrt = a;
        t.exp  = {er, ebv, es, ed, edn};
        vecs.push_back(t);
    endtask

    // One full LSB-first frame; the final row carries the inputs seen on the last cycle.
    task automatic play(input logic [7:0] fr, input logic v_mid, input logic [7:0] f_mid,
                        input logic v_last, input logic [7:0] f_last, input logic a_last);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) add(1'b0, v_last, f_last, a_last, 1'b1, 1'b1, 3'(k), fr[k], 1'b1);
            else        add(1'b0, v_mid, f_mid, 1'b0, 1'b0, 1'b1, 3'(k), fr[k], 1'b0);
        end
    endtask

    task automatic partial(input logic [7:0] fr, input int n);
        for (int k = 0; k < n; k++) add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'(k), fr[k], 1'b0);
    endtask

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    initial begin
        logic [2:0] es;
        logic       ed;

        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        play(8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        play(8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0);
        play(8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        partial(8'h3C, 4);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
        add(1'b0, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        play(8'h0F, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        partial(8'h5A, 5);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        play(8'h80, 1'b0, 8'h00, 1'b1, 8'h55, 1'b1);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

        rst = 1'b1; frame_in = 8'h00; frame_valid = 1'b0; abort = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            rst         = vecs[i].rst;
            frame_valid = vecs[i].vld;
            frame_in    = vecs[i].fr;
            abort       = vecs[i].abrt;
            #1;
            check($sformatf("vec%0d", i), {rdy_a, bv_a, sel_a, data_a, done_a}, vecs[i].exp);
            @(posedge clk); #1;
        end

        // HOLD_CYCLES=3, MSB-first: frame 8'h81 over 24 cycles, sel 7 down to 0.
        rst = 1'b1; frame_valid = 1'b0; abort = 1'b0; frame_in = 8'h00;
        @(posedge clk); #1;
        #1;
        check("msb_in_reset", {rdy_b, bv_b, sel_b, data_b, done_b}, 7'b0000000);
        rst = 1'b0;
        #1;
        check("msb_idle_ready", {rdy_b, bv_b, sel_b, data_b, done_b}, 7'b1000000);
        frame_valid = 1'b1; frame_in = 8'h81;
        @(posedge clk); #1;
        frame_valid = 1'b0; frame_in = 8'h00;
        for (int i = 0; i < 24; i++) begin
            #1;
            es = 3'(7 - i / 3);
            ed = (es == 3'd7) || (es == 3'd0);
            check($sformatf("msb_cyc%0d", i), {rdy_b, bv_b, sel_b, data_b, done_b},
                  {(i == 23), 1'b1, es, ed, (i == 23)});
            @(posedge clk); #1;
        end
        #1;
        check("msb_back_idle", {rdy_b, bv_b, sel_b, data_b, done_b}, 7'b1000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
